spi_display_responder: RTL and testbench

- Synthesizable SPI target model of the ILI9341-style display controller that the display driver in main talks to. It is the responder end of the display SPI link.
- Oversamples spi_clk, spi_mosi, display_csb and data_commandb in the system clock domain and decodes command and data bytes.
- Tracks the CASET/PASET window and emits one strobe per RAMWR pixel with its x/y coordinate and 16-bit colour.
- Used in benches and on-chip self-check to observe what main actually draws.

---
 rtl/spi_display_responder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_display_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_display_responder.sv
// SPI responder model of an ILI9341-style display: decodes command/data bytes,
// tracks the CASET/PASET window and strobes each RAMWR pixel. RDDID readback is built with SPI_DISPLAY_RESPONDER_RDDID_EN.
module spi_display_responder #(
    parameter int          WIDTH      = 240,
    parameter int          HEIGHT     = 320,
    parameter logic [23:0] DISPLAY_ID = 24'h009341
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        display_csb,
    input  logic                        spi_clk,
    input  logic                        spi_mosi,
    input  logic                        data_commandb,
    output logic                        spi_miso,
    output logic                        byte_valid,
    output logic [7:0]                  byte_data,
    output logic                        byte_is_data,
    output logic                        pixel_valid,
    output logic [$clog2(WIDTH)-1:0]    pixel_x,
    output logic [$clog2(HEIGHT)-1:0]   pixel_y,
    output logic [15:0]                 pixel_color,
    output logic                        cmd_error
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_CASET  = 3'd1,
        S_PASET  = 3'd2,
        S_RAMWR  = 3'd3,
        S_RDDID  = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    logic [1:0] sclk_sy_r, mosi_sy_r, dc_sy_r, csb_sy_r;
    logic       sclk_q_r, csb_q_r;
    logic       rise_s, rise_r, bit_r, dc_bit_r;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       byte_done_r, dc_cap_r;

    state_t          state_r, state_nx_s;
    logic [XW-1:0]   xs_r, xe_r, x_r;
    logic [YW-1:0]   ys_r, ye_r, y_r;
    logic [1:0]      par_cnt_r;
    logic [23:0]     par_r;
    logic [15:0]     start_s, end_s;
    logic            phase_r;
    logic [7:0]      color_hi_r;
    logic            pix_fire_s, commit_s;

    logic            byte_valid_r, byte_is_data_r, pixel_valid_r, cmd_error_r;
    logic [7:0]      byte_data_r;
    logic [XW-1:0]   pixel_x_r;
    logic [YW-1:0]   pixel_y_r;
    logic [15:0]     pixel_color_r;

    // Two-flop synchronizers plus previous-value flops for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sy_r <= 2'b00;
            mosi_sy_r <= 2'b00;
            dc_sy_r   <= 2'b00;
            csb_sy_r  <= 2'b11;
            sclk_q_r  <= 1'b0;
            csb_q_r   <= 1'b1;
        end else begin
            sclk_sy_r <= {sclk_sy_r[0], spi_clk};
            mosi_sy_r <= {mosi_sy_r[0], spi_mosi};
            dc_sy_r   <= {dc_sy_r[0], data_commandb};
            csb_sy_r  <= {csb_sy_r[0], display_csb};
            sclk_q_r  <= sclk_sy_r[1];
            csb_q_r   <= csb_sy_r[1];
        end
    end

    // Gate with the delayed csb so a csb rise coincident with the last edge still completes the byte
    assign rise_s = sclk_sy_r[1] & ~sclk_q_r & ~csb_q_r;

    // Registered rise strobe with the bit and dc value it captured, then the byte shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_r      <= 1'b0;
            bit_r       <= 1'b0;
            dc_bit_r    <= 1'b0;
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            dc_cap_r    <= 1'b0;
        end else begin
            rise_r   <= rise_s;
            bit_r    <= mosi_sy_r[1];
            dc_bit_r <= dc_sy_r[1];
            if (rise_r) begin
                shift_r     <= {shift_r[6:0], bit_r};
                bit_cnt_r   <= bit_cnt_r + 3'd1;
                byte_done_r <= (bit_cnt_r == 3'd7);
                if (bit_cnt_r == 3'd7) begin
                    dc_cap_r <= dc_bit_r;
                end
            end else begin
                byte_done_r <= 1'b0;
                if (csb_sy_r[1]) begin
                    bit_cnt_r <= 3'd0;
                end
            end
        end
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_CMD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Decoder next-state: any command byte re-targets, data bytes only finish CASET/PASET
    always_comb begin
        state_nx_s = state_r;
        if (byte_done_r && !dc_cap_r) begin
            case (shift_r)
                8'h2A:   state_nx_s = S_CASET;
                8'h2B:   state_nx_s = S_PASET;
                8'h2C:   state_nx_s = S_RAMWR;
                8'h01:   state_nx_s = S_CMD;
`ifdef SPI_DISPLAY_RESPONDER_RDDID_EN
                8'h04:   state_nx_s = S_RDDID;
`endif
                default: state_nx_s = S_IGNORE;
            endcase
        end else if (byte_done_r && (state_r == S_CASET || state_r == S_PASET) && par_cnt_r == 2'd3) begin
            state_nx_s = S_IGNORE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Decoder output strobes
    always_comb begin
        pix_fire_s = 1'b0;
        commit_s   = 1'b0;
        start_s    = par_r[23:8];
        end_s      = {par_r[7:0], shift_r};
        if (byte_done_r && dc_cap_r) begin
            pix_fire_s = (state_r == S_RAMWR) && phase_r;
            commit_s   = (par_cnt_r == 2'd3);
        end else begin
            pix_fire_s = 1'b0;
            commit_s   = 1'b0;
        end
    end

    // Window, pixel cursor and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            xs_r          <= {XW{1'b0}};
            xe_r          <= XW'(WIDTH - 1);
            ys_r          <= {YW{1'b0}};
            ye_r          <= YW'(HEIGHT - 1);
            x_r           <= {XW{1'b0}};
            y_r           <= {YW{1'b0}};
            par_cnt_r     <= 2'd0;
            par_r         <= 24'h000000;
            phase_r       <= 1'b0;
            color_hi_r    <= 8'h00;
            byte_valid_r  <= 1'b0;
            byte_data_r   <= 8'h00;
            byte_is_data_r <= 1'b0;
            pixel_valid_r <= 1'b0;
            pixel_x_r     <= {XW{1'b0}};
            pixel_y_r     <= {YW{1'b0}};
            pixel_color_r <= 16'h0000;
            cmd_error_r   <= 1'b0;
        end else begin
            byte_valid_r  <= byte_done_r;
            pixel_valid_r <= pix_fire_s;
            if (byte_done_r) begin
                byte_data_r    <= shift_r;
                byte_is_data_r <= dc_cap_r;
            end
            if (byte_done_r && !dc_cap_r) begin
                par_cnt_r <= 2'd0;
                if (shift_r == 8'h2C) begin
                    x_r     <= xs_r;
                    y_r     <= ys_r;
                    phase_r <= 1'b0;
                end
                if (shift_r == 8'h01) begin
                    xs_r <= {XW{1'b0}};
                    xe_r <= XW'(WIDTH - 1);
                    ys_r <= {YW{1'b0}};
                    ye_r <= YW'(HEIGHT - 1);
                end
            end else if (byte_done_r) begin
                case (state_r)
                    S_CMD: cmd_error_r <= 1'b1;
                    S_CASET, S_PASET: begin
                        par_cnt_r <= par_cnt_r + 2'd1;
                        par_r     <= {par_r[15:0], shift_r};
                        if (commit_s && state_r == S_CASET) begin
                            xs_r <= start_s[XW-1:0];
                            xe_r <= end_s[XW-1:0];
                        end
                        if (commit_s && state_r == S_PASET) begin
                            ys_r <= start_s[YW-1:0];
                            ye_r <= end_s[YW-1:0];
                        end
                    end
                    S_RAMWR: begin
                        phase_r <= ~phase_r;
                        if (!phase_r) begin
                            color_hi_r <= shift_r;
                        end else begin
                            pixel_x_r     <= x_r;
                            pixel_y_r     <= y_r;
                            pixel_color_r <= {color_hi_r, shift_r};
                            if (x_r == xe_r) begin
                                x_r <= xs_r;
                                y_r <= (y_r == ye_r) ? ys_r : y_r + YW'(1);
                            end else begin
                                x_r <= x_r + XW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_DISPLAY_RESPONDER_RDDID_EN
    logic        fall_s;
    logic [3:0]  dummy_cnt_r;
    logic [23:0] id_sh_r;
    logic        miso_r;

    assign fall_s = ~sclk_sy_r[1] & sclk_q_r;

    // RDDID readback: skip 8 dummy falls, then shift DISPLAY_ID out on each fall
    always_ff @(posedge clk) begin
        if (rst) begin
            dummy_cnt_r <= 4'd0;
            id_sh_r     <= 24'h000000;
            miso_r      <= 1'b0;
        end else if (byte_done_r && !dc_cap_r) begin
            dummy_cnt_r <= 4'd0;
            id_sh_r     <= DISPLAY_ID;
            miso_r      <= 1'b0;
        end else if (csb_sy_r[1]) begin
            miso_r <= 1'b0;
        end else if (fall_s && state_r == S_RDDID) begin
            if (dummy_cnt_r != 4'd8) begin
                dummy_cnt_r <= dummy_cnt_r + 4'd1;
                miso_r      <= 1'b0;
            end else begin
                miso_r  <= id_sh_r[23];
                id_sh_r <= {id_sh_r[22:0], 1'b0};
            end
        end
    end

    assign spi_miso = miso_r;
`else
    // Readback not built: the ID only feeds a constant-zero term
    assign spi_miso = 1'b0 & (^DISPLAY_ID);
`endif

    assign byte_valid   = byte_valid_r;
    assign byte_data    = byte_data_r;
    assign byte_is_data = byte_is_data_r;
    assign pixel_valid  = pixel_valid_r;
    assign pixel_x      = pixel_x_r;
    assign pixel_y      = pixel_y_r;
    assign pixel_color  = pixel_color_r;
    assign cmd_error    = cmd_error_r;
endmodule

// File: tb/tb_spi_display_responder.sv
// Directed bench for spi_display_responder; RDDID expectation follows SPI_DISPLAY_RESPONDER_RDDID_EN.
module tb_spi_display_responder;
    localparam int P = 6;

    logic        clk = 1'b0;
    logic        rst, display_csb, spi_clk, spi_mosi, data_commandb;
    logic        spi_miso, byte_valid, byte_is_data, pixel_valid, cmd_error;
    logic [7:0]  byte_data;
    logic [7:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [15:0] pixel_color;

    int checks = 0;
    int errors = 0;
    logic [7:0]  byte_q[$];
    logic [32:0] pix_q[$];
    logic [32:0] exp_pix[5];
    logic [31:0] rd;

    spi_display_responder dut (
        .clk(clk), .rst(rst), .display_csb(display_csb), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .data_commandb(data_commandb), .spi_miso(spi_miso),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_color(pixel_color), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) byte_q.push_back(byte_data);
        if (pixel_valid) pix_q.push_back({pixel_x, pixel_y, pixel_color});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_clk = 1'b0; spi_mosi = b[i]; data_commandb = dc;
            wclk(P);
            spi_clk = 1'b1;
            wclk(P);
        end
    endtask

    task automatic cs_lo();
        display_csb = 1'b0;
        wclk(P);
    endtask

    task automatic cs_hi();
        spi_clk = 1'b0;
        wclk(P);
        display_csb = 1'b1;
        wclk(P);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
        wclk(4);
    endtask

    initial begin
        display_csb = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; data_commandb = 1'b0;
        rst = 1'b1;
        wclk(2);
        check("rst_bytes", {byte_valid, byte_data, byte_is_data}, 64'd0);
        check("rst_pixel", {pixel_valid, pixel_x, pixel_y, pixel_color}, 64'd0);
        check("rst_misc", {spi_miso, cmd_error}, 64'd0);
        rst = 1'b0;
        wclk(4);

        // first pixel after reset
        cs_lo(); send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00); cs_hi();
        wclk(10);
        check("first_npix", pix_q.size(), 1);
        check("first_pix", pix_q[0], {8'd0, 9'd0, 16'hF800});
        check("first_bytes", {byte_q[0], byte_q[1], byte_q[2]}, 24'h2CF800);
        pix_q.delete(); byte_q.delete();

        // 2x2 window with frame wrap on the fifth pixel
        cs_lo();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0B);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h14); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h15);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send_byte(1'b1, 8'h07); send_byte(1'b1, 8'hE0);
        end
        cs_hi(); wclk(10);
        exp_pix[0] = {8'd10, 9'd20, 16'h07E0};
        exp_pix[1] = {8'd11, 9'd20, 16'h07E0};
        exp_pix[2] = {8'd10, 9'd21, 16'h07E0};
        exp_pix[3] = {8'd11, 9'd21, 16'h07E0};
        exp_pix[4] = {8'd10, 9'd20, 16'h07E0};
        check("win_npix", pix_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("win_pix%0d", i), pix_q[i], exp_pix[i]);
        check("win_cmderr", cmd_error, 1'b0);
        pix_q.delete();

        // SWRESET restores the full window
        cs_lo();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD);
        cs_hi(); wclk(10);
        check("swr_npix", pix_q.size(), 1);
        check("swr_pix", pix_q[0], {8'd0, 9'd0, 16'hABCD});
        pix_q.delete();

        // aborted CASET, then data under an unknown command
        cs_lo();
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07);
        send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
        send_byte(1'b0, 8'h00); send_byte(1'b1, 8'h55);
        cs_hi(); wclk(10);
        check("abort_npix", pix_q.size(), 1);
        check("abort_pix", pix_q[0], {8'd0, 9'd0, 16'h1122});
        check("ignore_cmderr", cmd_error, 1'b0);
        pix_q.delete(); byte_q.delete();

        // partial byte discarded by csb
        cs_lo();
        for (int i = 0; i < 5; i++) begin
            spi_clk = 1'b0; spi_mosi = 1'b1; data_commandb = 1'b1; wclk(P);
            spi_clk = 1'b1; wclk(P);
        end
        cs_hi();
        cs_lo(); send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34); cs_hi();
        wclk(10);
        check("part_nbytes", byte_q.size(), 3);
        check("part_bytes", {byte_q[0], byte_q[1], byte_q[2]}, 24'h2C1234);
        check("part_npix", pix_q.size(), 1);
        check("part_pix", pix_q[0], {8'd0, 9'd0, 16'h1234});
        pix_q.delete(); byte_q.delete();

        // RDDID readback
        rd = 32'h0;
        cs_lo(); send_byte(1'b0, 8'h04);
        for (int i = 0; i < 32; i++) begin
            spi_clk = 1'b0; spi_mosi = 1'b0; wclk(P);
            rd = {rd[30:0], spi_miso};
            spi_clk = 1'b1; wclk(P);
        end
        cs_hi(); wclk(4);
`ifdef SPI_DISPLAY_RESPONDER_RDDID_EN
        check("rddid", rd, 32'h00009341);
`else
        check("rddid", rd, 32'h00000000);
`endif
        check("miso_idle", spi_miso, 1'b0);

        // data byte straight after reset sets the sticky error
        do_reset();
        check("err_clear", cmd_error, 1'b0);
        cs_lo(); send_byte(1'b1, 8'h55); cs_hi(); wclk(10);
        check("err_set", cmd_error, 1'b1);
        cs_lo(); send_byte(1'b0, 8'h2C); cs_hi(); wclk(10);
        check("err_sticky", cmd_error, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
